// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, MMIO word
// offsets, FSM states and the byte-lane helpers used by stores.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  localparam logic [1:0] MMIO_IN  = 2'd0;
  localparam logic [1:0] MMIO_OUT = 2'd1;
  localparam logic [1:0] MMIO_CNT = 2'd2;
  localparam logic [1:0] MMIO_RSV = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Byte enables touched by an aligned access; reserved size behaves as word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: return 4'b0001 << lane;
      default:   return 4'b1111;
    endcase
  endfunction

  // Right-justified store data copied into every lane it could land in.
  function automatic logic [31:0] lane_repl(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_HALF: return {2{wdata[15:0]}};
      SIZE_BYTE: return {4{wdata[7:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data RAM bus of the MEM-stage access unit.
// master = pipeline + data RAM side, slave = the access unit.
interface mem_access_unit_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          stall;
  logic [31:0]   rdata;
  logic          misalign;
  logic          dm_en;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    input  stall, rdata, misalign, dm_en, dm_be, dm_addr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output stall, rdata, misalign, dm_en, dm_be, dm_addr, dm_wdata
  );
endinterface

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a 32-bit read word; shared by the
// RAM and MMIO read paths.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [15:0] half_f;
  logic [7:0]  byte_f;

  // Pick the addressed field, then extend from its top bit when signed.
  always_comb begin
    half_f = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_f = word[7:0];
      2'd1:    byte_f = word[15:8];
      2'd2:    byte_f = word[23:16];
      default: byte_f = word[31:24];
    endcase
    case (size)
      SIZE_HALF: data = {{16{sgn & half_f[15]}}, half_f};
      SIZE_BYTE: data = {{24{sgn & byte_f[7]}}, byte_f};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-access unit: byte-enabled data RAM accesses with a stalling
// load FSM, a 4-word MMIO window (synchronised inputs, output register,
// cycle counter) and misalignment detection.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW        = 8,
  parameter int RD_LAT    = 1,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 24,
  parameter int MMIO_BASE = 252
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out
);

  localparam logic [AW-1:0] MMIO_BASE_W = AW'(MMIO_BASE);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [AW-1:0]    widx_q, widx_d;
  logic [1:0]       lane_q, lane_d, size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [IN_W-1:0]  sync1_q, sync1_d, in_sync_q, in_sync_d;
  logic [OUT_W-1:0] gpio_out_q, gpio_out_d;
  logic [31:0]      cyc_q, cyc_d;

  logic [AW-1:0] widx, mmio_off_full;
  logic [1:0]    lane, mmio_off;
  logic          is_mmio, misalign_c, idle, done, accept;
  logic          ram_acc, ram_ld, mmio_rd, out_wr;
  logic [3:0]    be_c;
  logic [31:0]   wrep, mmio_word, ext_word, ext_data;
  logic [1:0]    ext_lane, ext_size;
  logic          ext_sgn;
  logic          unused_addr;

  assign widx          = bus.req_addr[AW+1:2];
  assign lane          = bus.req_addr[1:0];
  assign unused_addr   = ^bus.req_addr[31:AW+2];
  assign mmio_off_full = widx - MMIO_BASE_W;
  assign is_mmio       = mmio_off_full < AW'(4);
  assign mmio_off      = mmio_off_full[1:0];

  // Half must be 2-byte aligned; word (and reserved size) must be 4-byte aligned.
  assign misalign_c = bus.req_valid &
                      (((bus.req_size == SIZE_HALF) & lane[0]) |
                       ((bus.req_size != SIZE_HALF) & (bus.req_size != SIZE_BYTE) & (lane != 2'd0)));

  assign idle    = (state_q == ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign accept  = idle & bus.req_valid & ~misalign_c;
  assign ram_acc = accept & ~is_mmio;
  assign ram_ld  = ram_acc & ~bus.req_we;
  assign mmio_rd = accept & is_mmio & ~bus.req_we;
  assign out_wr  = accept & is_mmio & bus.req_we & (mmio_off == MMIO_OUT);
  assign be_c    = lane_mask(bus.req_size, lane);
  assign wrep    = lane_repl(bus.req_size, bus.req_wdata);

  // Load sequencing. cnt holds the RAM latency cycles still to come; the
  // cycle in which it would reach zero is DONE, so stall spans RD_LAT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    case (state_q)
      ST_IDLE: begin
        if (ram_ld) begin
          widx_d  = widx;
          lane_d  = lane;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          cnt_d   = 3'(RD_LAT - 1);
          state_d = (RD_LAT == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // MMIO read mux, gpio_out lane merge, input synchroniser and cycle counter.
  always_comb begin
    case (mmio_off)
      MMIO_IN:  mmio_word = 32'(in_sync_q);
      MMIO_OUT: mmio_word = 32'(gpio_out_q);
      MMIO_CNT: mmio_word = cyc_q;
      MMIO_RSV: mmio_word = 32'd0;
      default:  mmio_word = 32'd0;
    endcase
    gpio_out_d = gpio_out_q;
    if (out_wr) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (be_c[i/8]) gpio_out_d[i] = wrep[i];
      end
    end
    sync1_d   = gpio_in;
    in_sync_d = sync1_q;
    cyc_d     = cyc_q + 32'd1;
  end

  assign ext_word = done ? bus.dm_rdata : mmio_word;
  assign ext_lane = done ? lane_q : lane;
  assign ext_size = done ? size_q : bus.req_size;
  assign ext_sgn  = done ? sgn_q : bus.req_signed;

  load_extend u_load_extend (
    .word (ext_word),
    .lane (ext_lane),
    .size (ext_size),
    .sgn  (ext_sgn),
    .data (ext_data)
  );

  assign bus.rdata    = (done | mmio_rd) ? ext_data : 32'd0;
  assign bus.stall    = ram_ld | (state_q == ST_WAIT);
  assign bus.misalign = misalign_c;
  assign bus.dm_en    = ram_acc;
  assign bus.dm_be    = (ram_acc & bus.req_we) ? be_c : 4'b0000;
  assign bus.dm_addr  = idle ? widx : widx_q;
  assign bus.dm_wdata = wrep;
  assign gpio_out     = gpio_out_q;

  // State, captured request fields and MMIO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      widx_q     <= '0;
      lane_q     <= 2'd0;
      size_q     <= 2'd0;
      sgn_q      <= 1'b0;
      sync1_q    <= '0;
      in_sync_q  <= '0;
      gpio_out_q <= '0;
      cyc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      sync1_q    <= sync1_d;
      in_sync_q  <= in_sync_d;
      gpio_out_q <= gpio_out_d;
      cyc_q      <= cyc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit with RD_LAT=3.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int AW        = 8;
  localparam int RD_LAT    = 3;
  localparam int IN_W      = 12;
  localparam int OUT_W     = 24;
  localparam int MMIO_BASE = 252;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  gpio_in = '0;
  logic [OUT_W-1:0] gpio_out;

  mem_access_unit_if #(.AW(AW)) bus ();

  mem_access_unit #(
    .AW(AW), .RD_LAT(RD_LAT), .IN_W(IN_W), .OUT_W(OUT_W), .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- data RAM environment (RD_LAT read latency) -------------
  logic [31:0]   ram [0:(1<<AW)-1];
  logic [31:0]   rd_pipe [0:RD_LAT-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [3:0] be,
                                           input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= (bus.dm_en && bus.dm_be == 4'b0) ? ram[bus.dm_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (bus.dm_en && bus.dm_be != 4'b0)
      ram[bus.dm_addr] <= merge_be(ram[bus.dm_addr], bus.dm_be, bus.dm_wdata);
  end
  assign bus.dm_rdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------------------------------
  logic [31:0]     ref_mem [0:(1<<AW)-1];
  logic [31:0]     ref_gpio = '0;
  logic [31:0]     ref_cyc;
  logic [IN_W-1:0] gin_hist [$];

  // cycle count = clock edges seen since reset released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cyc <= 32'd0;
    else        ref_cyc <= ref_cyc + 32'd1;
  end

  // gpio_in value present at each clock edge since reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gin_hist.delete();
    else begin
      gin_hist.push_back(gpio_in);
      if (gin_hist.size() > 4) void'(gin_hist.pop_front());
    end
  end

  function automatic logic [31:0] ref_gin();
    if (gin_hist.size() < 2) return 32'd0;
    return 32'(gin_hist[gin_hist.size()-2]);
  endfunction

  function automatic logic [31:0] ref_extend(input logic [31:0] w, input int lane, input int size,
                                             input logic sgn);
    logic [31:0] v;
    if (size == 1) begin
      v = (w >> (16 * (lane / 2))) & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (size == 2) begin
      v = (w >> (8 * lane)) & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else v = w;
    return v;
  endfunction

  function automatic logic ref_misalign(input int size, input int lane);
    return (size == 1 && lane % 2 == 1) || ((size == 0 || size == 3) && lane != 0);
  endfunction

  function automatic logic [3:0] ref_be(input int size, input int lane);
    if (size == 1) return (lane < 2) ? 4'b0011 : 4'b1100;
    if (size == 2) return 4'(1 << lane);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wrep(input int size, input logic [31:0] wd);
    if (size == 1) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    if (size == 2) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    return wd;
  endfunction

  // ---------------- stimulus tasks -----------------------------------------
  task automatic ram_poke(input int w, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = 1'b0;
    pre_en = 1'b1; pre_addr = AW'(w); pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[w] = d;
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd_obs);
    int w, lane, sz, off, nst;
    logic mis, mm;
    logic [31:0] exp_rd, src;
    logic [3:0] be;
    w = int'(addr[AW+1:2]); lane = int'(addr[1:0]); sz = int'(size);
    mis = ref_misalign(sz, lane);
    mm  = (w >= MMIO_BASE) && (w <= MMIO_BASE + 3);
    off = w - MMIO_BASE;
    be  = ref_be(sz, lane);
    @(negedge clk);
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    #2;
    rd_obs = bus.rdata;
    check_eq("gpio_out", 32'(gpio_out), ref_gpio);
    check_eq("misalign", 32'(bus.misalign), 32'(mis));
    if (mis) begin
      check_eq("mis_stall", 32'(bus.stall), 32'd0);
      check_eq("mis_dm_en", 32'(bus.dm_en), 32'd0);
      check_eq("mis_rdata", bus.rdata, 32'd0);
      @(posedge clk);
    end else if (mm) begin
      check_eq("mmio_stall", 32'(bus.stall), 32'd0);
      check_eq("mmio_dm_en", 32'(bus.dm_en), 32'd0);
      if (!we) begin
        case (off)
          0:       src = ref_gin();
          1:       src = ref_gpio;
          2:       src = ref_cyc;
          default: src = 32'd0;
        endcase
        exp_rd = ref_extend(src, lane, sz, sgn);
        check_eq("mmio_rdata", bus.rdata, exp_rd);
      end
      @(posedge clk);
      if (we && off == 1)
        ref_gpio = merge_be(ref_gpio, be, ref_wrep(sz, wd)) & ((32'd1 << OUT_W) - 32'd1);
    end else if (we) begin
      check_eq("st_stall", 32'(bus.stall), 32'd0);
      check_eq("st_dm_en", 32'(bus.dm_en), 32'd1);
      check_eq("st_dm_be", 32'(bus.dm_be), 32'(be));
      check_eq("st_dm_addr", 32'(bus.dm_addr), 32'(w));
      check_eq("st_dm_wdata", bus.dm_wdata, ref_wrep(sz, wd));
      @(posedge clk);
      ref_mem[w] = merge_be(ref_mem[w], be, ref_wrep(sz, wd));
    end else begin
      exp_rd = ref_extend(ref_mem[w], lane, sz, sgn);
      check_eq("ld_stall", 32'(bus.stall), 32'd1);
      check_eq("ld_dm_en", 32'(bus.dm_en), 32'd1);
      check_eq("ld_dm_be", 32'(bus.dm_be), 32'd0);
      check_eq("ld_dm_addr", 32'(bus.dm_addr), 32'(w));
      nst = 1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); @(negedge clk); #2;
        if (!bus.stall) break;
        nst++;
        check_eq("ld_dm_en_wait", 32'(bus.dm_en), 32'd0);
      end
      check_eq("ld_stall_cycles", 32'(nst), 32'(RD_LAT));
      rd_obs = bus.rdata;
      check_eq("ld_rdata", bus.rdata, exp_rd);
      @(posedge clk);
    end
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    logic [31:0] r, r2, r3, a;
    int w;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    for (int i = 0; i < 32; i++) ram_poke(i, $urandom());
    @(negedge clk); #2;
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_misalign", 32'(bus.misalign), 32'd0);
    check_eq("rst_dm_en", 32'(bus.dm_en), 32'd0);
    check_eq("rst_dm_be", 32'(bus.dm_be), 32'd0);
    check_eq("rst_gpio_out", 32'(gpio_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    ram_poke(4, 32'h12C4_5678);
    run_txn(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0011, 32'd0, r);
    check_eq("lb_0x11", r, 32'h0000_0056);
    run_txn(1'b1, SIZE_HALF, 1'b0, 32'h0000_0022, 32'h0000_BEEF, r);
    ram_poke(4, 32'h80FF_0000);
    run_txn(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0013, 32'd0, r);
    check_eq("lbu_0x13", r, 32'h0000_0080);
    run_txn(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0013, 32'd0, r);
    check_eq("lb_0x13", r, 32'hFFFF_FF80);
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'h0000_0006, 32'd0, r);
    run_txn(1'b1, SIZE_BYTE, 1'b0, 32'(MMIO_BASE*4 + 5), 32'h0000_00A5, r);
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4 + 4), 32'd0, r);
    check_eq("gpio_sb_lane1", r, 32'h0000_A500);

    #1 gpio_in = 12'hABC;
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4), 32'd0, r);
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4), 32'd0, r2);
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4), 32'd0, r3);
    check_eq("gin_clk1", r, 32'd0);
    check_eq("gin_clk2", r2, 32'd0);
    check_eq("gin_clk3", r3, 32'h0000_0ABC);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        #1 gpio_in = IN_W'($urandom());
      end
      case ($urandom_range(0, 3))
        2:       w = MMIO_BASE + int'($urandom_range(0, 3));
        default: w = int'($urandom_range(0, 31));
      endcase
      a = $urandom();
      a[AW+1:2] = AW'(w);
      a[1:0] = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom(), r);
    end

    run_txn(1'b1, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4 + 4), 32'h0012_3456, r);
    ram_poke(5, 32'hCAFE_F00D);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = SIZE_WORD; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0014; bus.req_valid = 1'b1;
    @(posedge clk); @(negedge clk); #2;
    check_eq("wait_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0; ref_gpio = 32'd0;
    bus.req_addr = 32'(MMIO_BASE*4 + 8);
    #1;
    check_eq("rst_mid_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_mid_gpio", 32'(gpio_out), 32'd0);
    check_eq("rst_mid_cnt", bus.rdata, 32'd0);
    bus.req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'(MMIO_BASE*4 + 8), 32'd0, r);
    check_eq("cnt_after_rst", r, 32'd1);
    run_txn(1'b0, SIZE_WORD, 1'b0, 32'h0000_0014, 32'd0, r);
    check_eq("ld_after_rst", r, 32'hCAFE_F00D);

    @(negedge clk) bus.req_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
